// File: rtl/updown_load_counter_if.sv
// rtl/updown_load_counter_if.sv - control and count signals of the up/down load counter
interface updown_load_counter_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic             enable;
  logic             count_up_down;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] count_out;
  logic             terminate_cnt;

  // Sequencing logic: drives load/step controls, observes the count
  modport master (
    output load,
    output enable,
    output count_up_down,
    output data_in,
    input  count_out,
    input  terminate_cnt
  );

  // Counter: takes the controls, returns the count and terminal flag
  modport slave (
    input  load,
    input  enable,
    input  count_up_down,
    input  data_in,
    output count_out,
    output terminate_cnt
  );
endinterface

// File: rtl/updown_load_counter.sv
// rtl/updown_load_counter.sv - loadable up/down counter with terminal-count flag
module updown_load_counter #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  updown_load_counter_if.slave  cnt_if
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: load beats a step, a step beats hold; wraps modulo 2^WIDTH
  always_comb begin
    count_d = count_q;
    if (cnt_if.load) begin
      count_d = cnt_if.data_in;
    end else if (cnt_if.enable) begin
      if (cnt_if.count_up_down) begin
        count_d = count_q + ONE;
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  // Count register; reset clears it without waiting for a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign cnt_if.count_out = count_q;

  // Terminal count is the last value before wrapping in the current direction
  assign cnt_if.terminate_cnt = cnt_if.count_up_down ? (count_q == '1) : (count_q == '0);

endmodule

// File: tb/tb_updown_load_counter.sv
// tb/tb_updown_load_counter.sv - randomized self-checking bench for updown_load_counter
module tb_updown_load_counter;

  localparam int WIDTH = 8;
  localparam int MODULUS = 1 << WIDTH;

  logic clk;
  logic rst_n;

  updown_load_counter_if #(.WIDTH(WIDTH)) cnt_if ();

  updown_load_counter #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cnt_if (cnt_if)
  );

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Terminal flag as defined: last value before wrap in the chosen direction
  function automatic int exp_term(input logic up, input int cnt);
    if (up) return (cnt == MODULUS - 1) ? 1 : 0;
    return (cnt == 0) ? 1 : 0;
  endfunction

  // Apply controls for one clock, advance the reference model, check outputs
  task automatic cycle(input string tag, input logic ld, input logic en,
                       input logic up, input logic [WIDTH-1:0] din);
    cnt_if.load          = ld;
    cnt_if.enable        = en;
    cnt_if.count_up_down = up;
    cnt_if.data_in       = din;
    @(posedge clk);
    if (!rst_n) model_cnt = 0;
    else if (ld) model_cnt = int'(din);
    else if (en && up) model_cnt = (model_cnt + 1) % MODULUS;
    else if (en) model_cnt = (model_cnt + MODULUS - 1) % MODULUS;
    #1;
    check({tag, "_count"}, 32'(cnt_if.count_out), 32'(model_cnt));
    check({tag, "_term"}, 32'(cnt_if.terminate_cnt), 32'(exp_term(up, model_cnt)));
  endtask

  // Assert reset between clock edges and check it acts before the next edge
  task automatic async_reset(input string tag, input logic up);
    cnt_if.count_up_down = up;
    #3;
    rst_n = 1'b0;
    #1;
    model_cnt = 0;
    check({tag, "_rst_count"}, 32'(cnt_if.count_out), 32'd0);
    check({tag, "_rst_term"}, 32'(cnt_if.terminate_cnt), 32'(exp_term(up, 0)));
    cycle({tag, "_in_rst"}, 1'b1, 1'b1, up, 8'hA5);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n                = 1'b0;
    cnt_if.load          = 1'b0;
    cnt_if.enable        = 1'b0;
    cnt_if.count_up_down = 1'b0;
    cnt_if.data_in       = '0;
    #1;
    check("por_count", 32'(cnt_if.count_out), 32'd0);
    check("por_term", 32'(cnt_if.terminate_cnt), 32'd1);
    cycle("por", 1'b0, 1'b1, 1'b1, 8'h00);
    rst_n = 1'b1;

    // Mid-count reset from 8'h05
    cycle("ld5", 1'b1, 1'b0, 1'b0, 8'h05);
    check("ld5_value", 32'(cnt_if.count_out), 32'h05);
    async_reset("mid", 1'b0);

    // Load 7 then count down through zero
    cycle("ld7", 1'b1, 1'b0, 1'b0, 8'h07);
    for (int i = 0; i < 7; i++) cycle("down", 1'b0, 1'b1, 1'b0, 8'h00);
    check("down_zero", 32'(cnt_if.count_out), 32'h00);
    check("down_zero_term", 32'(cnt_if.terminate_cnt), 32'd1);
    cycle("down_wrap", 1'b0, 1'b1, 1'b0, 8'h00);
    check("down_wrap_ff", 32'(cnt_if.count_out), 32'hFF);
    check("down_wrap_term", 32'(cnt_if.terminate_cnt), 32'd0);

    // Count up through all-ones
    cycle("ldfd", 1'b1, 1'b0, 1'b1, 8'hFD);
    cycle("up_fe", 1'b0, 1'b1, 1'b1, 8'h00);
    cycle("up_ff", 1'b0, 1'b1, 1'b1, 8'h00);
    check("up_ff_term", 32'(cnt_if.terminate_cnt), 32'd1);
    cycle("up_00", 1'b0, 1'b1, 1'b1, 8'h00);
    check("up_wrap_00", 32'(cnt_if.count_out), 32'h00);

    // Hold, then load beating enable
    for (int i = 0; i < 5; i++) cycle("hold", 1'b0, 1'b0, 1'b0, 8'h77);
    check("hold_value", 32'(cnt_if.count_out), 32'h00);
    cycle("ld_en", 1'b1, 1'b1, 1'b0, 8'h3C);
    check("ld_wins", 32'(cnt_if.count_out), 32'h3C);

    // Direction flip at zero changes the flag without a clock
    cycle("ld0", 1'b1, 1'b0, 1'b0, 8'h00);
    check("flip_down_term", 32'(cnt_if.terminate_cnt), 32'd1);
    cnt_if.count_up_down = 1'b1;
    #1;
    check("flip_up_term", 32'(cnt_if.terminate_cnt), 32'd0);
    cycle("flip_step", 1'b0, 1'b1, 1'b1, 8'h00);
    check("flip_count1", 32'(cnt_if.count_out), 32'h01);

    // Bit sequencing: load 7, enable every second clock
    cycle("seq_ld", 1'b1, 1'b1, 1'b0, 8'h07);
    for (int i = 1; i <= 14; i++) begin
      cycle("seq", 1'b0, 1'(i % 2 == 0), 1'b0, 8'h00);
      if (i == 13) check("seq_before_end", 32'(cnt_if.count_out), 32'h01);
    end
    check("seq_end", 32'(cnt_if.count_out), 32'h00);
    for (int i = 0; i < 4; i++) cycle("seq_idle", 1'b0, 1'b0, 1'b0, 8'h00);
    check("seq_stay", 32'(cnt_if.count_out), 32'h00);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_reset("rnd", 1'($urandom_range(0, 1)));
      end else begin
        cycle("rnd", 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 8'($urandom));
        if ($urandom_range(0, 9) == 0) begin
          cnt_if.count_up_down = ~cnt_if.count_up_down;
          #1;
          check("rnd_flip_term", 32'(cnt_if.terminate_cnt),
                32'(exp_term(cnt_if.count_up_down, model_cnt)));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
